// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment capture block:
//   - active-low segment patterns for digits 0-9 and blank, written as
//     [0:6] = {a,b,c,d,e,f,g}, so the literal reads a..g from left to right
//   - internal code values for blank and for an unrecognised pattern
//   - number of digits captured
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [3:0] code_t;
    typedef logic [0:6] seg_t;

    localparam int NUM_DIGITS = 4;

    localparam seg_t PAT_0     = 7'b0000001;
    localparam seg_t PAT_1     = 7'b1001111;
    localparam seg_t PAT_2     = 7'b0010010;
    localparam seg_t PAT_3     = 7'b0000110;
    localparam seg_t PAT_4     = 7'b1001100;
    localparam seg_t PAT_5     = 7'b0100100;
    localparam seg_t PAT_6     = 7'b0100000;
    localparam seg_t PAT_7     = 7'b0001111;
    localparam seg_t PAT_8     = 7'b0000000;
    localparam seg_t PAT_9     = 7'b0000100;
    localparam seg_t PAT_BLANK = 7'b1111111;

    localparam code_t CODE_BLANK   = 4'hF;
    localparam code_t CODE_ILLEGAL = 4'hE;

endpackage

// File: rtl/seg7_to_code.sv
// ---------------------------------------------------------------------------
// seg7_to_code
// Purely combinational pattern-to-code table.
//   pattern [0:6] : active-low segment pattern, index 0 = segment a
//   code    [3:0] : 0-9 for digits, 4'hF for blank, 4'hE for anything else
// ---------------------------------------------------------------------------
module seg7_to_code (
    input  logic [0:6] pattern,
    output logic [3:0] code
);
    import seg7_pkg::*;

    always_comb begin
        case (pattern)
            PAT_0:     code = 4'd0;
            PAT_1:     code = 4'd1;
            PAT_2:     code = 4'd2;
            PAT_3:     code = 4'd3;
            PAT_4:     code = 4'd4;
            PAT_5:     code = 4'd5;
            PAT_6:     code = 4'd6;
            PAT_7:     code = 4'd7;
            PAT_8:     code = 4'd8;
            PAT_9:     code = 4'd9;
            PAT_BLANK: code = CODE_BLANK;
            default:   code = CODE_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/seg7_capture_bcd.sv
// ---------------------------------------------------------------------------
// seg7_capture_bcd
// Captures a multiplexed, active-low seven-segment bus and turns it into
// debounced BCD digits. A digit only commits after STABLE_CNT consecutive
// identical samples addressed to it.
//   CLOCK_50         : sole clock, rising edge
//   RESET            : synchronous, active-high
//   HEX_IN  [0:6]    : segment bus, 0 = lit, index 0 = segment a
//   DIG_SEL [3:0]    : one-hot digit strobe for the current HEX_IN
//   BCD_OUT [15:0]   : committed digits, digit n in [4n+3:4n], F = blank
//   ERR     [3:0]    : last commit on digit n was an unrecognised pattern
//   VALID            : one-cycle pulse after any BCD_OUT/ERR change
// Pipeline: bus registered at edge k, count update and commit at edge k+1.
// ---------------------------------------------------------------------------
module seg7_capture_bcd #(
    parameter int STABLE_CNT = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [0:6]  HEX_IN,
    input  logic [3:0]  DIG_SEL,
    output logic [15:0] BCD_OUT,
    output logic [3:0]  ERR,
    output logic        VALID
);
    import seg7_pkg::*;

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CNT);

    logic [0:6] hex_reg;
    logic [3:0] sel_reg;
    logic [3:0] code;
    logic       sample_ok;
    logic [3:0] change;
    logic       valid_reg;

    // Stage 1: register the raw bus. Clearing the strobe on reset is what
    // discards the sample that was in flight.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hex_reg <= PAT_BLANK;
            sel_reg <= '0;
        end else begin
            hex_reg <= HEX_IN;
            sel_reg <= DIG_SEL;
        end
    end

    seg7_to_code u_decode (
        .pattern (hex_reg),
        .code    (code)
    );

    // Zero or multi-hot strobes are bus glitches and are ignored outright.
    assign sample_ok = $onehot(sel_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] cand_reg;
            logic [3:0] cnt_reg;
            logic [3:0] field_reg;
            logic       err_reg;
            logic       hit;
            logic       same;
            logic       commit;

            assign hit  = sample_ok & sel_reg[gi];
            assign same = (code == cand_reg);
            // Commit only on the step into STABLE_CNT; once saturated the
            // count holds and no further commits fire.
            assign commit = hit & same & (cnt_reg == (STABLE_LIM - 4'd1));

            assign change[gi] = commit &
                ((code == CODE_ILLEGAL) ? ~err_reg
                                        : (err_reg | (field_reg != code)));

            always_ff @(posedge CLOCK_50) begin
                if (RESET) begin
                    cand_reg  <= CODE_BLANK;
                    cnt_reg   <= 4'd0;
                    field_reg <= CODE_BLANK;
                    err_reg   <= 1'b0;
                end else if (hit) begin
                    if (same) begin
                        if (cnt_reg < STABLE_LIM) begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end else begin
                        cand_reg <= code;
                        cnt_reg  <= 4'd1;
                    end
                    if (commit) begin
                        if (code == CODE_ILLEGAL) begin
                            // Keep the last good digit visible, flag the error.
                            err_reg <= 1'b1;
                        end else begin
                            field_reg <= code;
                            err_reg   <= 1'b0;
                        end
                    end
                end
            end

            assign BCD_OUT[4*gi +: 4] = field_reg;
            assign ERR[gi]            = err_reg;
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= |change;
        end
    end

    assign VALID = valid_reg;

endmodule

// File: tb/tb_seg7_capture_bcd.sv
// ---------------------------------------------------------------------------
// tb_seg7_capture_bcd
// Directed vector table for the documented scenarios, then randomized
// traffic checked against a run-length reference model. Inputs change on
// the falling edge; outputs are compared on the falling edge two samples
// after the input that produced them.
// ---------------------------------------------------------------------------
module tb_seg7_capture_bcd;

    localparam int STABLE = 4;

    localparam logic [0:6] P0 = 7'b0000001;
    localparam logic [0:6] P1 = 7'b1001111;
    localparam logic [0:6] P2 = 7'b0010010;
    localparam logic [0:6] P3 = 7'b0000110;
    localparam logic [0:6] P4 = 7'b1001100;
    localparam logic [0:6] P5 = 7'b0100100;
    localparam logic [0:6] P6 = 7'b0100000;
    localparam logic [0:6] P7 = 7'b0001111;
    localparam logic [0:6] P8 = 7'b0000000;
    localparam logic [0:6] P9 = 7'b0000100;
    localparam logic [0:6] PB = 7'b1111111;
    localparam logic [0:6] PX = 7'b1111110;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:6]  hex;
    logic [3:0]  sel;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        valid;

    always #5 clk = ~clk;

    seg7_capture_bcd #(.STABLE_CNT(STABLE)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .HEX_IN   (hex),
        .DIG_SEL  (sel),
        .BCD_OUT  (bcd),
        .ERR      (err),
        .VALID    (valid)
    );

    typedef struct {
        logic [0:6]  hex;
        logic [3:0]  sel;
        logic        rst;
        logic [15:0] bcd;
        logic [3:0]  err;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  err;
        logic        valid;
    } exp_t;

    vec_t  vecs[$];
    exp_t  pipe0, pipe1;
    bit    live0 = 0, live1 = 0;
    string name0, name1;
    int    checks = 0;
    int    errors = 0;

    logic [0:6] pat_tbl [0:10];

    // Reference model state: last code seen and its run length per digit.
    logic [3:0]  m_last [4];
    int          m_run  [4];
    logic [15:0] m_bcd;
    logic [3:0]  m_err;

    function automatic logic [3:0] ref_decode(input logic [0:6] p);
        for (int i = 0; i < 11; i++) begin
            if (pat_tbl[i] == p) return (i == 10) ? 4'hF : 4'(i);
        end
        return 4'hE;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.bcd = 16'hFFFF;
        e.err = 4'h0;
        e.valid = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One sample per call: compare the sample from two calls ago, then drive.
    task automatic cycle(input logic [0:6] h, input logic [3:0] s, input logic r,
                         input exp_t e, input string tag);
        @(negedge clk);
        if (live1) begin
            check({name1, " bcd"},   bcd,           pipe1.bcd);
            check({name1, " err"},   16'(err),      16'(pipe1.err));
            check({name1, " valid"}, 16'(valid),    16'(pipe1.valid));
            $display("%s: bcd=%h err=%b valid=%b", name1, bcd, err, valid);
        end
        pipe1 = pipe0;
        live1 = live0;
        name1 = name0;
        pipe0 = e;
        live0 = 1'b1;
        name0 = tag;
        if (r) begin
            // The sample already registered is discarded by the reset edge.
            pipe1 = reset_exp();
            live1 = 1'b1;
            pipe0 = reset_exp();
        end
        hex = h;
        sel = s;
        rst = r;
    endtask

    task automatic model_step(input logic [0:6] h, input logic [3:0] s, input logic r,
                              output exp_t e);
        logic [15:0] old_bcd;
        logic [3:0]  old_err;
        logic [3:0]  c;
        int          d;
        e.valid = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_last[i] = 4'hF;
                m_run[i]  = 0;
            end
            m_bcd = 16'hFFFF;
            m_err = 4'h0;
        end else if ($countones(s) == 1) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (s[i]) d = i;
            c = ref_decode(h);
            if (c == m_last[d]) m_run[d]++;
            else begin
                m_last[d] = c;
                m_run[d]  = 1;
            end
            if (m_run[d] == STABLE) begin
                old_bcd = m_bcd;
                old_err = m_err;
                if (c == 4'hE) m_err[d] = 1'b1;
                else begin
                    m_bcd[4*d +: 4] = c;
                    m_err[d] = 1'b0;
                end
                e.valid = (m_bcd != old_bcd) || (m_err != old_err);
            end
        end
        e.bcd = m_bcd;
        e.err = m_err;
    endtask

    task automatic add(input logic [0:6] h, input logic [3:0] s, input logic r,
                       input logic [15:0] b, input logic [3:0] e, input logic v);
        vec_t x;
        x.hex = h; x.sel = s; x.rst = r; x.bcd = b; x.err = e; x.valid = v;
        vecs.push_back(x);
    endtask

    // n identical samples: all but the last leave (b0,e0); the last gives (b1,e1,v).
    task automatic rep(input logic [0:6] h, input logic [3:0] s, input int n,
                       input logic [15:0] b0, input logic [3:0] e0,
                       input logic [15:0] b1, input logic [3:0] e1, input logic v);
        for (int i = 0; i < n - 1; i++) add(h, s, 1'b0, b0, e0, 1'b0);
        add(h, s, 1'b0, b1, e1, v);
    endtask

    initial begin
        exp_t e;
        logic [0:6] rh;
        logic [3:0] rs;
        logic       rr;
        int         k;
        int         run;
        logic [15:0] rb [4];
        logic       rv [4];

        pat_tbl[0] = P0; pat_tbl[1] = P1; pat_tbl[2] = P2; pat_tbl[3] = P3;
        pat_tbl[4] = P4; pat_tbl[5] = P5; pat_tbl[6] = P6; pat_tbl[7] = P7;
        pat_tbl[8] = P8; pat_tbl[9] = P9; pat_tbl[10] = PB;

        rst = 1'b1;
        hex = PB;
        sel = 4'h0;

        // Reset and idle with no strobes.
        add(PB, 4'h0, 1'b1, 16'hFFFF, 4'h0, 1'b0);
        add(PB, 4'h0, 1'b1, 16'hFFFF, 4'h0, 1'b0);
        rep(PB, 4'h0, 3, 16'hFFFF, 4'h0, 16'hFFFF, 4'h0, 1'b0);
        // Digit 0 = 2 after four samples; a fifth gives no pulse.
        rep(P2, 4'h1, 4, 16'hFFFF, 4'h0, 16'hFFF2, 4'h0, 1'b1);
        add(P2, 4'h1, 1'b0, 16'hFFF2, 4'h0, 1'b0);
        // Digit 1: three 4s then four 5s -> only 5 commits.
        rep(P4, 4'h2, 3, 16'hFFF2, 4'h0, 16'hFFF2, 4'h0, 1'b0);
        rep(P5, 4'h2, 4, 16'hFFF2, 4'h0, 16'hFF52, 4'h0, 1'b1);
        // Digit 2: 9, then illegal keeps 9 and flags, then 0 clears.
        rep(P9, 4'h4, 4, 16'hFF52, 4'h0, 16'hF952, 4'h0, 1'b1);
        rep(PX, 4'h4, 4, 16'hF952, 4'h0, 16'hF952, 4'h4, 1'b1);
        rep(P0, 4'h4, 4, 16'hF952, 4'h4, 16'hF052, 4'h0, 1'b1);
        // Round-robin scan with a multi-hot glitch in round 2.
        rb[0] = 16'hF053; rb[1] = 16'hF073; rb[2] = 16'hF873; rb[3] = 16'hF873;
        rv[0] = 1'b1;     rv[1] = 1'b1;     rv[2] = 1'b1;     rv[3] = 1'b0;
        for (int rnd = 1; rnd <= 4; rnd++) begin
            for (int d = 0; d < 4; d++) begin
                if (rnd == 2 && d == 2) add(P1, 4'h3, 1'b0, 16'hF052, 4'h0, 1'b0);
                if (rnd < 4) add(pat_tbl[d == 0 ? 3 : d == 1 ? 7 : d == 2 ? 8 : 10],
                                 4'(1 << d), 1'b0, 16'hF052, 4'h0, 1'b0);
                else         add(pat_tbl[d == 0 ? 3 : d == 1 ? 7 : d == 2 ? 8 : 10],
                                 4'(1 << d), 1'b0, rb[d], 4'h0, rv[d]);
            end
        end
        add(PB, 4'h0, 1'b0, 16'hF873, 4'h0, 1'b0);
        add(PB, 4'h0, 1'b0, 16'hF873, 4'h0, 1'b0);
        // Reset after three of four samples on digit 3; four fresh ones needed.
        rep(P6, 4'h8, 3, 16'hF873, 4'h0, 16'hF873, 4'h0, 1'b0);
        add(P6, 4'h8, 1'b1, 16'hFFFF, 4'h0, 1'b0);
        rep(P6, 4'h8, 3, 16'hFFFF, 4'h0, 16'hFFFF, 4'h0, 1'b0);
        add(P6, 4'h8, 1'b0, 16'h6FFF, 4'h0, 1'b1);
        add(PB, 4'h0, 1'b0, 16'h6FFF, 4'h0, 1'b0);
        add(PB, 4'h0, 1'b0, 16'h6FFF, 4'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            e.bcd = vecs[i].bcd;
            e.err = vecs[i].err;
            e.valid = vecs[i].valid;
            cycle(vecs[i].hex, vecs[i].sel, vecs[i].rst, e, $sformatf("dir%0d", i));
        end

        // Randomized traffic against the reference model.
        model_step(PB, 4'h0, 1'b1, e);
        cycle(PB, 4'h0, 1'b1, e, "rnd_reset");
        k = 0;
        while (k < 900) begin
            run = $urandom_range(6, 1);
            case ($urandom_range(9, 0))
                7:       rs = 4'h0;
                8, 9:    rs = 4'($urandom);
                default: rs = 4'(1 << $urandom_range(3, 0));
            endcase
            if ($urandom_range(9, 0) < 8) rh = pat_tbl[$urandom_range(10, 0)];
            else                          rh = 7'($urandom);
            for (int j = 0; j < run; j++) begin
                rr = ($urandom_range(99, 0) == 0);
                model_step(rh, rs, rr, e);
                cycle(rh, rs, rr, e, $sformatf("rnd%0d", k));
                k++;
            end
        end
        for (int j = 0; j < 2; j++) begin
            model_step(PB, 4'h0, 1'b0, e);
            cycle(PB, 4'h0, 1'b0, e, $sformatf("flush%0d", j));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
